btn_event_ctrl: RTL and testbench

Collects debounced button levels from the `DeBounce` instances and turns their edges into a single ordered stream of press/release events. A round-robin arbiter shares one event FIFO among all buttons. The OS-facing consumer drains the FIFO over a valid/ready handshake. It sits between the button debouncers and the CPU I/O register block.

---
 rtl/btn_evt_pkg.sv | 15 +
 rtl/evt_fifo.sv | 43 ++++
 rtl/btn_event_ctrl.sv | 86 ++++++++
 tb/tb_btn_event_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: event kind encoding and arbiter helpers shared by the button event controller.
package btn_evt_pkg;
    localparam logic KIND_PRESS   = 1'b0;
    localparam logic KIND_RELEASE = 1'b1;
    localparam int   MAX_NB       = 16;

    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

    // With both edges pending the current level tells which came last, so the other one is older.
    function automatic logic evt_kind(input logic pp, input logic pr, input logic prev);
        return (pp && pr) ? (prev ? KIND_RELEASE : KIND_PRESS) : (pr ? KIND_RELEASE : KIND_PRESS);
    endfunction
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: show-ahead FIFO with occupancy count; push while full is accepted only alongside a pop.
module evt_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push, w_pop;

    assign o_valid = r_cnt != '0;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;
    assign w_pop   = i_pop & o_valid;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: turns debounced button edges into one ordered press/release stream,
// sharing a single event FIFO among all buttons through a round-robin arbiter.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int NB    = 4,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(NB)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NB-1:0]            db_in,
    input  logic [NB-1:0]            en,
    output logic                     ev_valid,
    output logic [IDX_W:0]           ev_data,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     ovf,
    input  logic                     ovf_clr
);
    typedef struct packed {
        logic             kind;
        logic [IDX_W-1:0] idx;
    } evt_t;

    logic [NB-1:0]    r_prev, r_pp, r_pr;
    logic [IDX_W-1:0] r_ptr;
    logic             r_ovf;
    logic [NB-1:0]    w_rise, w_fall, w_req, w_clr_pp, w_clr_pr, w_pp_nxt, w_pr_nxt;
    logic             w_pop, w_full, w_can, w_gnt, w_lost;
    logic [IDX_W-1:0] w_gidx;
    evt_t             w_evt;

    assign w_rise = db_in & ~r_prev & en;
    assign w_fall = ~db_in & r_prev & en;
    assign w_req  = r_pp | r_pr;
    assign w_pop  = ev_valid & ev_ready;
    assign w_can  = ~w_full | w_pop;

    // Scan from the farthest slot down so the request nearest the pointer is the last assignment.
    always_comb begin
        w_gnt  = 1'b0;
        w_gidx = '0;
        for (int k = NB - 1; k >= 0; k--)
            if (w_can && w_req[IDX_W'(rr_idx(int'(r_ptr), k, NB))]) begin
                w_gnt  = 1'b1;
                w_gidx = IDX_W'(rr_idx(int'(r_ptr), k, NB));
            end
    end

    assign w_evt.kind = evt_kind(r_pp[w_gidx], r_pr[w_gidx], r_prev[w_gidx]);
    assign w_evt.idx  = w_gidx;
    assign w_clr_pp   = (w_gnt && w_evt.kind == KIND_PRESS)   ? (NB'(1) << w_gidx) : '0;
    assign w_clr_pr   = (w_gnt && w_evt.kind == KIND_RELEASE) ? (NB'(1) << w_gidx) : '0;
    assign w_pp_nxt   = (r_pp & ~w_clr_pp) | w_rise;
    assign w_pr_nxt   = (r_pr & ~w_clr_pr) | w_fall;
    assign w_lost     = |((r_pp & ~w_clr_pp & w_rise) | (r_pr & ~w_clr_pr & w_fall));
    assign ovf        = r_ovf;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_prev <= '0;
            r_pp   <= '0;
            r_pr   <= '0;
            r_ptr  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_prev <= db_in;
            r_pp   <= w_pp_nxt;
            r_pr   <= w_pr_nxt;
            if (w_gnt) r_ptr <= IDX_W'(rr_idx(int'(w_gidx), 1, NB));
            r_ovf  <= w_lost | (r_ovf & ~ovf_clr);
        end

    evt_fifo #(.W(IDX_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_gnt),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_valid (ev_valid),
        .o_full  (w_full),
        .o_data  (ev_data),
        .o_count (ev_count)
    );
endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed and random stimulus against a queue-based behavioural event model.
module tb_btn_event_ctrl;
    localparam int NB    = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = $clog2(NB);

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NB-1:0]          db_in = '0;
    logic [NB-1:0]          en = '1;
    logic                   ev_ready = 1'b0;
    logic                   ovf_clr = 1'b0;
    logic                   ev_valid;
    logic [IDX_W:0]         ev_data;
    logic [$clog2(DEPTH):0] ev_count;
    logic                   ovf;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_lvl[NB];
    bit m_pp[NB];
    bit m_pr[NB];
    int m_next;
    bit m_ovf;
    int m_q[$];

    btn_event_ctrl #(.NB(NB), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .db_in    (db_in),
        .en       (en),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .ev_count (ev_count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_lvl[i] = 0;
            m_pp[i]  = 0;
            m_pr[i]  = 0;
        end
        m_next = 0;
        m_ovf  = 0;
        m_q.delete();
    endtask

    // One clock of the event rules, evaluated on the inputs about to be sampled.
    task automatic model_step();
        bit pop  = m_q.size() != 0 && ev_ready;
        bit room = m_q.size() < DEPTH || pop;
        bit lost = 0;
        int g    = -1;
        if (room)
            for (int k = 0; k < NB; k++) begin
                int j = (m_next + k) % NB;
                if (g < 0 && (m_pp[j] || m_pr[j])) g = j;
            end
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            bit rel = (m_pp[g] && m_pr[g]) ? m_lvl[g] : m_pr[g];
            m_q.push_back((int'(rel) << IDX_W) | g);
            if (rel) m_pr[g] = 0;
            else m_pp[g] = 0;
            m_next = (g + 1) % NB;
        end
        for (int i = 0; i < NB; i++) begin
            if (en[i] && db_in[i] != m_lvl[i]) begin
                if (db_in[i]) begin
                    if (m_pp[i]) lost = 1;
                    m_pp[i] = 1;
                end else begin
                    if (m_pr[i]) lost = 1;
                    m_pr[i] = 1;
                end
            end
            m_lvl[i] = db_in[i];
        end
        m_ovf = lost || (m_ovf && !ovf_clr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", 32'(ev_valid), 32'(m_q.size() != 0));
        chk("count", 32'(ev_count), 32'(m_q.size()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (m_q.size() != 0) chk("data", 32'(ev_data), 32'(m_q[0]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_count", 32'(ev_count), 32'd0);
        chk("rst_data", 32'(ev_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        model_reset();
        #20;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        apply_reset();
        ev_ready = 1'b1;

        db_in[2] = 1'b1;
        tick();
        chk("lat_n1", 32'(ev_valid), 32'd0);
        tick();
        chk("lat_n2", 32'(ev_valid), 32'd1);
        chk("press2", 32'(ev_data), 32'h2);
        tick();
        db_in[2] = 1'b0;
        ticks(2);
        chk("rel2", 32'(ev_data), 32'h6);
        ticks(3);

        apply_reset();
        db_in = 4'b1011;
        ticks(2);
        chk("rr_0", 32'(ev_data), 32'h0);
        tick();
        chk("rr_1", 32'(ev_data), 32'h1);
        tick();
        chk("rr_3", 32'(ev_data), 32'h3);
        ticks(2);
        db_in = 4'b0000;
        ticks(2);
        db_in = 4'b0011;
        ticks(8);

        db_in = 4'b0000;
        ticks(8);
        ev_ready = 1'b0;
        db_in = 4'b1111;
        tick();
        db_in[0] = 1'b0;
        ticks(6);
        chk("full_cnt", 32'(ev_count), 32'(DEPTH));
        chk("full_ovf", 32'(ovf), 32'd0);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        tick();
        chk("refill", 32'(ev_count), 32'(DEPTH));

        db_in[1] = 1'b0;
        tick();
        db_in[1] = 1'b1;
        tick();
        chk("two_kinds_ovf", 32'(ovf), 32'd0);
        db_in[1] = 1'b0;
        tick();
        chk("ovf_set", 32'(ovf), 32'd1);
        db_in[1] = 1'b1;
        tick();
        ev_ready = 1'b1;
        ticks(10);
        chk("ovf_hold", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        ev_ready = 1'b0;
        db_in = 4'b0001;
        ticks(4);
        chk("queued3", 32'(ev_count), 32'd3);
        apply_reset();
        ev_ready = 1'b1;
        ticks(2);
        chk("post_rst_v", 32'(ev_valid), 32'd1);
        chk("post_rst_d", 32'(ev_data), 32'h0);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 3) == 0) db_in[i] = ~db_in[i];
                en[i] = $urandom_range(0, 7) != 0;
            end
            ev_ready = (c % 64 < 20) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr  = $urandom_range(0, 15) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
